// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryptor. It expands the round keys forward into a register file,
// then runs one inverse round per clock using those keys in reverse order.
module aes_decrypt_iter (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] in,
   input  logic [127:0] key,
   output logic [127:0] out,
   output logic         busy,
   output logic         done
);

   typedef enum logic [1:0] {IDLE, KEYEXP, INIT, ROUND} state_t;

   state_t       state_reg;
   logic [3:0]   cnt_reg;
   logic [3:0]   rnd_reg;
   logic [127:0] out_reg;
   logic         busy_reg;
   logic         done_reg;
   logic [127:0] ct_reg;
   logic [127:0] st_reg;
   logic [127:0] rk_reg [0:10];

   logic [127:0] sb_next;
   logic [127:0] ark_next;
   logic [127:0] st_next;
   logic [127:0] rk_prev;
   logic [127:0] rk_next;
   logic [31:0]  rot_word;
   logic [31:0]  sub_word;
   logic [31:0]  temp_word;
   logic [3:0]   prev_idx;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254; this also maps 0 to 0, as the S-box needs.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] r;
      logic [7:0] p;
      r = 8'h01;
      p = x;
      for (int i = 1; i < 8; i++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] b;
      b = gf_inv(x);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] x);
      return gf_inv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] idx);
      logic [7:0] r;
      case (idx)
         4'd1:    r = 8'h01;
         4'd2:    r = 8'h02;
         4'd3:    r = 8'h04;
         4'd4:    r = 8'h08;
         4'd5:    r = 8'h10;
         4'd6:    r = 8'h20;
         4'd7:    r = 8'h40;
         4'd8:    r = 8'h80;
         4'd9:    r = 8'h1b;
         4'd10:   r = 8'h36;
         default: r = 8'h00;
      endcase
      return r;
   endfunction

   // InvShiftRows folded into the byte routing: s'[r][c] = s[r][(c - r) mod 4].
   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_inv_sub
         localparam int ROW = gi % 4;
         localparam int COL = gi / 4;
         localparam int SRC = ROW + 4 * ((COL - ROW + 4) % 4);
         assign sb_next[127-8*gi -: 8] = inv_sbox(st_reg[127-8*SRC -: 8]);
      end
   endgenerate

   assign ark_next = sb_next ^ rk_reg[rnd_reg];

   generate
      for (gi = 0; gi < 4; gi++) begin : g_inv_mix
         logic [7:0] a0, a1, a2, a3;
         assign a0 = ark_next[127-32*gi -: 8];
         assign a1 = ark_next[119-32*gi -: 8];
         assign a2 = ark_next[111-32*gi -: 8];
         assign a3 = ark_next[103-32*gi -: 8];
         assign st_next[127-32*gi -: 32] = {
            gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
      end
   endgenerate

   assign prev_idx = cnt_reg - 4'd1;
   assign rk_prev  = rk_reg[prev_idx];
   assign rot_word = {rk_prev[23:0], rk_prev[31:24]};

   generate
      for (gi = 0; gi < 4; gi++) begin : g_sub_word
         assign sub_word[31-8*gi -: 8] = sbox(rot_word[31-8*gi -: 8]);
      end
   endgenerate

   assign temp_word           = sub_word ^ {rcon(cnt_reg), 24'h000000};
   assign rk_next[127:96]     = rk_prev[127:96] ^ temp_word;
   assign rk_next[95:64]      = rk_prev[95:64] ^ rk_next[127:96];
   assign rk_next[63:32]      = rk_prev[63:32] ^ rk_next[95:64];
   assign rk_next[31:0]       = rk_prev[31:0] ^ rk_next[63:32];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= 4'd0;
         rnd_reg   <= 4'd0;
         out_reg   <= 128'h0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  cnt_reg   <= 4'd1;
                  busy_reg  <= 1'b1;
                  state_reg <= KEYEXP;
               end
            end
            KEYEXP: begin
               cnt_reg <= cnt_reg + 4'd1;
               if (cnt_reg == 4'd10) state_reg <= INIT;
            end
            INIT: begin
               rnd_reg   <= 4'd9;
               state_reg <= ROUND;
            end
            ROUND: begin
               if (rnd_reg == 4'd0) begin
                  out_reg   <= ark_next;
                  done_reg  <= 1'b1;
                  busy_reg  <= 1'b0;
                  state_reg <= IDLE;
               end else begin
                  rnd_reg <= rnd_reg - 4'd1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Key file and state carry no reset; their contents are only consumed after a fresh start.
   always_ff @(posedge clk) begin
      case (state_reg)
         IDLE: begin
            if (start) begin
               ct_reg    <= in;
               rk_reg[0] <= key;
            end
         end
         KEYEXP:  rk_reg[cnt_reg] <= rk_next;
         INIT:    st_reg <= ct_reg ^ rk_reg[10];
         ROUND:   st_reg <= st_next;
         default: ;
      endcase
   end

   assign out  = out_reg;
   assign busy = busy_reg;
   assign done = done_reg;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Directed bench for aes_decrypt_iter using FIPS-197 and all-zero-key vectors.
module tb_aes_decrypt_iter;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] Z_KEY  = 128'h0;
   localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
   localparam logic [127:0] Z_PT   = 128'h0;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [127:0] in_v = 128'h0;
   logic [127:0] key_v = 128'h0;
   logic [127:0] out_v;
   logic         busy;
   logic         done;

   int n_vec = 0;
   int n_err = 0;

   aes_decrypt_iter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .in    (in_v),
      .key   (key_v),
      .out   (out_v),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launches one block and waits for done; lat = -1 on timeout.
   task automatic run_block(input logic [127:0] ct, input logic [127:0] k,
                            output int lat, output int busy_cycles);
      start = 1'b1;
      in_v  = ct;
      key_v = k;
      tick();
      start = 1'b0;
      lat = 0;
      busy_cycles = busy ? 1 : 0;
      while (!done && lat < 100) begin
         tick();
         lat++;
         if (busy) busy_cycles++;
      end
      if (!done) lat = -1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b1;
      in_v  = C1_CT;
      key_v = C1_KEY;
      repeat (3) tick();
      n_vec++;
      if (out_v !== 128'h0) begin
         n_err++;
         $display("FAIL reset_out: got %h expected %h", out_v, 128'h0);
      end
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_busy_start_held: got %b expected 0", busy);
      end
      n_vec++;
      if (done !== 1'b0) begin
         n_err++;
         $display("FAIL reset_done: got %b expected 0", done);
      end
      start = 1'b0;
      rst_n = 1'b1;
      tick();
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL idle_after_reset_busy: got %b expected 0", busy);
      end
      $display("test_reset: out=%h busy=%b done=%b", out_v, busy, done);
   endtask

   task automatic test_fips_c1();
      int lat, bc;
      run_block(C1_CT, C1_KEY, lat, bc);
      n_vec++;
      if (lat !== 21) begin
         n_err++;
         $display("FAIL c1_latency: got %0d edges expected 21", lat);
      end
      n_vec++;
      if (out_v !== C1_PT) begin
         n_err++;
         $display("FAIL c1_out: got %h expected %h", out_v, C1_PT);
      end
      tick();
      n_vec++;
      if (done !== 1'b0) begin
         n_err++;
         $display("FAIL c1_done_one_cycle: got %b expected 0", done);
      end
      n_vec++;
      if (out_v !== C1_PT) begin
         n_err++;
         $display("FAIL c1_out_hold: got %h expected %h", out_v, C1_PT);
      end
      $display("test_fips_c1: latency=%0d out=%h", lat, out_v);
   endtask

   task automatic test_fips_b();
      int lat, bc;
      run_block(B_CT, B_KEY, lat, bc);
      n_vec++;
      if (lat !== 21) begin
         n_err++;
         $display("FAIL b_latency: got %0d edges expected 21", lat);
      end
      n_vec++;
      if (out_v !== B_PT) begin
         n_err++;
         $display("FAIL b_out: got %h expected %h", out_v, B_PT);
      end
      n_vec++;
      if (bc !== 21) begin
         n_err++;
         $display("FAIL b_busy_cycles: got %0d expected 21", bc);
      end
      tick();
      $display("test_fips_b: latency=%0d busy_cycles=%0d out=%h", lat, bc, out_v);
   endtask

   task automatic test_ignore_start();
      int lat, extra;
      start = 1'b1;
      in_v  = C1_CT;
      key_v = C1_KEY;
      tick();
      start = 1'b0;
      lat = 0;
      repeat (4) begin
         tick();
         lat++;
      end
      start = 1'b1;
      in_v  = B_CT;
      key_v = B_KEY;
      tick();
      lat++;
      start = 1'b0;
      n_vec++;
      if (out_v !== B_PT) begin
         n_err++;
         $display("FAIL ignore_out_hold_midop: got %h expected %h", out_v, B_PT);
      end
      while (!done && lat < 100) begin
         tick();
         lat++;
      end
      if (!done) lat = -1;
      n_vec++;
      if (lat !== 21) begin
         n_err++;
         $display("FAIL ignore_latency: got %0d edges expected 21", lat);
      end
      n_vec++;
      if (out_v !== C1_PT) begin
         n_err++;
         $display("FAIL ignore_out: got %h expected %h", out_v, C1_PT);
      end
      extra = 0;
      repeat (25) begin
         tick();
         if (done || busy) extra++;
      end
      n_vec++;
      if (extra !== 0) begin
         n_err++;
         $display("FAIL ignore_single_done: got %0d busy/done cycles expected 0", extra);
      end
      $display("test_ignore_start: latency=%0d out=%h", lat, out_v);
   endtask

   task automatic test_back_to_back();
      int lat, bc, gap;
      run_block(Z_CT, Z_KEY, lat, bc);
      n_vec++;
      if (out_v !== Z_PT || lat !== 21) begin
         n_err++;
         $display("FAIL b2b_first_out: got %h after %0d edges expected %h after 21", out_v, lat, Z_PT);
      end
      start = 1'b1;
      in_v  = C1_CT;
      key_v = C1_KEY;
      tick();
      start = 1'b0;
      gap = 1;
      n_vec++;
      if (busy !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_accept_busy: got %b expected 1", busy);
      end
      n_vec++;
      if (out_v !== Z_PT) begin
         n_err++;
         $display("FAIL b2b_out_hold: got %h expected %h", out_v, Z_PT);
      end
      while (!done && gap < 100) begin
         tick();
         gap++;
      end
      if (!done) gap = -1;
      n_vec++;
      if (gap !== 22) begin
         n_err++;
         $display("FAIL b2b_gap: got %0d cycles expected 22", gap);
      end
      n_vec++;
      if (out_v !== C1_PT) begin
         n_err++;
         $display("FAIL b2b_second_out: got %h expected %h", out_v, C1_PT);
      end
      tick();
      $display("test_back_to_back: gap=%0d out=%h", gap, out_v);
   endtask

   task automatic test_reset_abort();
      int lat, bc, seen;
      start = 1'b1;
      in_v  = B_CT;
      key_v = B_KEY;
      tick();
      start = 1'b0;
      repeat (8) tick();
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (out_v !== 128'h0) begin
         n_err++;
         $display("FAIL abort_out: got %h expected %h", out_v, 128'h0);
      end
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL abort_busy: got %b expected 0", busy);
      end
      n_vec++;
      if (done !== 1'b0) begin
         n_err++;
         $display("FAIL abort_done: got %b expected 0", done);
      end
      repeat (2) tick();
      rst_n = 1'b1;
      seen = 0;
      repeat (30) begin
         tick();
         if (done || busy) seen++;
      end
      n_vec++;
      if (seen !== 0) begin
         n_err++;
         $display("FAIL abort_no_done: got %0d busy/done cycles expected 0", seen);
      end
      run_block(C1_CT, C1_KEY, lat, bc);
      n_vec++;
      if (lat !== 21) begin
         n_err++;
         $display("FAIL abort_restart_latency: got %0d edges expected 21", lat);
      end
      n_vec++;
      if (out_v !== C1_PT) begin
         n_err++;
         $display("FAIL abort_restart_out: got %h expected %h", out_v, C1_PT);
      end
      $display("test_reset_abort: restart latency=%0d out=%h", lat, out_v);
   endtask

   initial begin
      test_reset();
      test_fips_c1();
      test_fips_b();
      test_ignore_start();
      test_back_to_back();
      test_reset_abort();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
